board_input_debouncer: RTL and testbench

Conditions raw board pushbuttons and slide switches (mode/rw, step, etc.) before they reach the RISC-V core and its clock/control logic. This is the input-side counterpart to the clock divider and seven-segment output path in the FPGA top level. Each channel is synchronised to `clk`, sampled at a slow prescaled rate, and accepted only after a run of identical samples. The block outputs a clean level per channel and single-cycle rise and fall pulses, which downstream logic uses for single-step and run-control decisions.

---
 rtl/board_input_debouncer.sv | 125 ++++++++++++
 tb/tb_board_input_debouncer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_debouncer.sv
// Board pushbutton/switch conditioner: two-flop synchroniser, prescaled sampling,
// and per-channel run-length qualification producing clean levels plus edge pulses.
module board_input_debouncer #(
    parameter int NUM_INPUTS    = 4,
    parameter int TICK_DIV      = 50000,
    parameter int STABLE_COUNT  = 8,
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] btn_raw,
    output logic [NUM_INPUTS-1:0] btn_level,
    output logic [NUM_INPUTS-1:0] btn_rise,
    output logic [NUM_INPUTS-1:0] btn_fall,
    output logic                  sample_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_COUNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_COUNT - 1);
    localparam logic [NUM_INPUTS-1:0] RAW_IDLE = ACTIVE_LOW_IN ? {NUM_INPUTS{1'b1}}
                                                               : {NUM_INPUTS{1'b0}};

    typedef enum logic {
        CH_IDLE       = 1'b0,
        CH_QUALIFYING = 1'b1
    } chan_state_e;

    logic [NUM_INPUTS-1:0] sync1;
    logic [NUM_INPUTS-1:0] sync2;
    logic [NUM_INPUTS-1:0] s;
    logic [PW-1:0]         presc;
    logic                  tick_q;

    logic [CW-1:0]         cnt      [NUM_INPUTS];
    logic [CW-1:0]         cnt_nxt  [NUM_INPUTS];
    chan_state_e           chan_state [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] level_q;
    logic [NUM_INPUTS-1:0] level_nxt;
    logic [NUM_INPUTS-1:0] rise_q;
    logic [NUM_INPUTS-1:0] rise_nxt;
    logic [NUM_INPUTS-1:0] fall_q;
    logic [NUM_INPUTS-1:0] fall_nxt;

    // Sync flops idle at the raw-inactive value so reset release never looks like a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign s = ACTIVE_LOW_IN ? ~sync2 : sync2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (presc == PRESC_LAST);
            presc  <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    // Channel state register: counter, accepted level and edge pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt[i] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            level_q <= level_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            chan_state[i] = (cnt[i] == '0) ? CH_IDLE : CH_QUALIFYING;
        end
    end

    // Next-state: only a sample tick may move a channel; pulses default low.
    always_comb begin
        level_nxt = level_q;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (tick_q) begin
                if (s[i] == level_q[i]) begin
                    if (chan_state[i] == CH_QUALIFYING) begin
                        cnt_nxt[i] = '0;
                    end
                end else if (cnt[i] == CNT_LAST) begin
                    level_nxt[i] = s[i];
                    rise_nxt[i]  = s[i];
                    fall_nxt[i]  = ~s[i];
                    cnt_nxt[i]   = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        btn_level   = level_q;
        btn_rise    = rise_q;
        btn_fall    = fall_q;
        sample_tick = tick_q;
    end

endmodule

// File: tb/tb_board_input_debouncer.sv
// Directed bench for board_input_debouncer: per-cycle comparison against a
// window-based model of the acceptance rule, plus hand-computed literal checks.
module tb_board_input_debouncer;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam bit AL = 1'b1;
    localparam logic [N-1:0] RAW_IDLE = {N{1'b1}};

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic [N-1:0] btn_raw = {N{1'b1}};
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;
    logic         sample_tick;

    int checks = 0;
    int errors = 0;

    board_input_debouncer #(
        .NUM_INPUTS   (N),
        .TICK_DIV     (TD),
        .STABLE_COUNT (SC),
        .ACTIVE_LOW_IN(AL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level flips at a tick when the last SC tick samples since the
    // previous flip all disagree with it; samples are the raw pins two edges back.
    logic [N-1:0] raw_hist [$];
    logic [N-1:0] samples  [$];
    int           change_idx [N];
    int           n_edges;
    logic         m_tick;
    logic [N-1:0] m_level;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    logic         model_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [N-1:0] smp;
        int           k;
        bit           ok;
        if (!reset) begin
            raw_hist.delete();
            raw_hist.push_back(RAW_IDLE);
            raw_hist.push_back(RAW_IDLE);
            samples.delete();
            for (int i = 0; i < N; i++) change_idx[i] = 0;
            n_edges = 0;
            m_tick  = 1'b0;
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            smp = raw_hist[raw_hist.size() - 2];
            if (AL) smp = ~smp;
            m_rise = '0;
            m_fall = '0;
            if (m_tick) begin
                samples.push_back(smp);
                k = samples.size();
                for (int i = 0; i < N; i++) begin
                    if (k - change_idx[i] >= SC) begin
                        ok = 1'b1;
                        for (int j = k - SC; j < k; j++) begin
                            if (samples[j][i] == m_level[i]) ok = 1'b0;
                        end
                        if (ok) begin
                            m_level[i]    = smp[i];
                            m_rise[i]     = smp[i];
                            m_fall[i]     = ~smp[i];
                            change_idx[i] = k;
                        end
                    end
                end
            end
            raw_hist.push_back(btn_raw);
            n_edges++;
            m_tick = ((n_edges % TD) == 0);
        end
        model_valid = 1'b1;
    end

    int rise0_cnt = 0;
    int fall0_cnt = 0;
    int rise_tot  = 0;
    int fall_tot  = 0;

    always @(negedge clk) begin
        if (model_valid) begin
            check("level", 32'(btn_level), 32'(m_level));
            check("rise",  32'(btn_rise),  32'(m_rise));
            check("fall",  32'(btn_fall),  32'(m_fall));
            check("tick",  32'(sample_tick), 32'(m_tick));
            check("rise_fall_overlap", 32'(btn_rise & btn_fall), 32'd0);
            rise0_cnt += int'(btn_rise[0]);
            fall0_cnt += int'(btn_fall[0]);
            rise_tot  += $countones(btn_rise);
            fall_tot  += $countones(btn_fall);
        end
    end

    task automatic wait_tick();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!sample_tick && c < 2 * TD + 2);
        check("tick_wait", 32'(sample_tick), 32'd1);
    endtask

    task automatic wait_level(input int ch, input logic val);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (btn_level[ch] !== val && c < 60);
        check("level_wait", 32'(btn_level[ch]), 32'(val));
    endtask

    initial begin : stim
        int cyc;
        int r0, f0, rt, ft;

        // Reset held with keys released
        reset   = 1'b0;
        btn_raw = '1;
        repeat (5) @(negedge clk);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_rise",  32'(btn_rise),  32'd0);
        check("rst_fall",  32'(btn_fall),  32'd0);
        check("rst_tick",  32'(sample_tick), 32'd0);
        reset = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!sample_tick && cyc < 20);
        check("first_tick_delay", 32'(cyc), 32'd4);
        for (int p = 0; p < 2; p++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!sample_tick && cyc < 20);
            check("tick_period", 32'(cyc), 32'd4);
        end

        // Clean press on channel 0
        r0 = rise0_cnt; f0 = fall0_cnt;
        btn_raw[0] = 1'b0;
        wait_level(0, 1'b1);
        check("press_rise_vec", 32'(btn_rise), 32'b0001);
        repeat (3) @(negedge clk);
        check("press_rise_cnt", 32'(rise0_cnt - r0), 32'd1);
        check("press_fall_cnt", 32'(fall0_cnt - f0), 32'd0);

        // Release on channel 0
        r0 = rise0_cnt; f0 = fall0_cnt;
        btn_raw[0] = 1'b1;
        wait_level(0, 1'b0);
        check("release_fall_vec", 32'(btn_fall), 32'b0001);
        repeat (3) @(negedge clk);
        check("release_fall_cnt", 32'(fall0_cnt - f0), 32'd1);
        check("release_rise_cnt", 32'(rise0_cnt - r0), 32'd0);

        // Bounce: 0 for two ticks, 1 for one tick, then 0
        r0 = rise0_cnt;
        wait_tick();
        btn_raw[0] = 1'b0;
        wait_tick();
        wait_tick();
        btn_raw[0] = 1'b1;
        wait_tick();
        btn_raw[0] = 1'b0;
        wait_tick();
        wait_tick();
        check("bounce_level_hold", 32'(btn_level[0]), 32'd0);
        wait_tick();
        check("bounce_level_tick6", 32'(btn_level[0]), 32'd0);
        @(negedge clk);
        check("bounce_level_accept", 32'(btn_level[0]), 32'd1);
        check("bounce_rise_vec", 32'(btn_rise), 32'b0001);
        repeat (2) @(negedge clk);
        check("bounce_rise_cnt", 32'(rise0_cnt - r0), 32'd1);

        // Simultaneous press on channels 3..1
        btn_raw[3:1] = 3'b000;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (btn_level[3:1] !== 3'b111 && cyc < 60);
        check("simul_level", 32'(btn_level), 32'b1111);
        check("simul_rise_vec", 32'(btn_rise), 32'b1110);
        @(negedge clk);
        check("simul_rise_clear", 32'(btn_rise), 32'd0);

        // Release everything
        btn_raw = '1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (btn_level !== 4'b0000 && cyc < 60);
        check("all_released", 32'(btn_level), 32'd0);

        // Reset after two qualifying ticks discards the run
        wait_tick();
        btn_raw[0] = 1'b0;
        wait_tick();
        wait_tick();
        rt = rise_tot; ft = fall_tot;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midq_level", 32'(btn_level), 32'd0);
        wait_tick();
        wait_tick();
        check("midq_no_pulse", 32'(rise_tot - rt + fall_tot - ft), 32'd0);
        wait_tick();
        check("midq_level_tick3", 32'(btn_level[0]), 32'd0);
        @(negedge clk);
        check("midq_level_accept", 32'(btn_level[0]), 32'd1);
        check("midq_rise_vec", 32'(btn_rise), 32'b0001);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
